// File: rtl/cap_buffer_ctrl.sv
// Capture buffer controller: circular packet buffer in a single-port RAM,
// filled by the capture engine and drained to a host reader once per session.
module cap_buffer_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int PACKET_WIDTH = 32,
  parameter int FULL_MARGIN  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    cap_idle,
  input  logic                    wr_en,
  input  logic [PACKET_WIDTH-1:0] wr_data,
  output logic                    page_full,
  input  logic                    rd_req,
  output logic                    rd_valid,
  output logic [PACKET_WIDTH-1:0] rd_data,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [PACKET_WIDTH-1:0] mem_wdata,
  input  logic [PACKET_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH:0]     count,
  output logic                    overflow,
  output logic                    busy,
  output logic                    done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - FULL_MARGIN);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    READOUT
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  in_flight;
  logic                  idle_armed;
  logic                  do_write;
  logic                  drop_write;
  logic                  do_read;
  logic                  session_start;
  logic                  readout_end;

  // A write always owns the RAM port; reads only issue on write-free cycles.
  always_comb begin
    do_write   = 1'b0;
    drop_write = 1'b0;
    do_read    = 1'b0;
    if (!abort) begin
      if (state == CAPTURE && wr_en) begin
        do_write   = (count != COUNT_FULL);
        drop_write = (count == COUNT_FULL);
      end
      if ((state == CAPTURE || state == READOUT) && rd_req && count != '0 &&
          !wr_en && !in_flight) begin
        do_read = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (do_write) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_ptr;
      mem_wdata = wr_data;
    end else if (do_read) begin
      mem_en   = 1'b1;
      mem_addr = rd_ptr;
    end
  end

  // cap_idle only ends a capture once it has been seen low inside the session.
  always_comb begin
    state_next    = state;
    session_start = 1'b0;
    readout_end   = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next    = CAPTURE;
            session_start = 1'b1;
          end
        end
        CAPTURE: begin
          if (cap_idle && idle_armed) begin
            state_next = READOUT;
          end
        end
        READOUT: begin
          if (count == '0 && !in_flight) begin
            state_next  = IDLE;
            readout_end = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    count_next = count;
    if (abort || session_start) begin
      count_next = '0;
    end else if (do_write) begin
      count_next = count + COUNT_ONE;
    end else if (do_read) begin
      count_next = count - COUNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idle_armed <= 1'b0;
      done       <= 1'b0;
      page_full  <= 1'b0;
      count      <= '0;
    end else begin
      state      <= state_next;
      done       <= readout_end;
      page_full  <= (count_next >= FULL_LEVEL) && (state_next == CAPTURE);
      count      <= count_next;
      if (session_start) begin
        idle_armed <= 1'b0;
      end else if (state == CAPTURE && !cap_idle) begin
        idle_armed <= 1'b1;
      end
    end
  end

  // Pointers wrap naturally at DEPTH; equal pointers with a full count means full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (session_start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop_write) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      in_flight <= do_read;
      rd_valid  <= in_flight && !abort;
      if (in_flight) begin
        rd_data <= mem_rdata;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cap_buffer_ctrl.sv
// Randomized and directed bench for cap_buffer_ctrl against a queue-based
// session model; a small registered RAM stands in for the sample memory.
module tb_cap_buffer_ctrl;

  localparam int AW    = 4;
  localparam int PW    = 32;
  localparam int FM    = 2;
  localparam int DEPTH = 2 ** AW;

  localparam int M_IDLE    = 0;
  localparam int M_CAPTURE = 1;
  localparam int M_READOUT = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic          cap_idle;
  logic          wr_en;
  logic [PW-1:0] wr_data;
  logic          page_full;
  logic          rd_req;
  logic          rd_valid;
  logic [PW-1:0] rd_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_wdata;
  logic [PW-1:0] mem_rdata;
  logic [AW:0]   count;
  logic          overflow;
  logic          busy;
  logic          done;

  int vectors;
  int miscompares;

  int            m_st;
  logic [PW-1:0] m_q[$];
  int            m_wr_total;
  int            m_rd_total;
  bit            m_infl;
  logic [PW-1:0] m_infl_data;
  bit            m_rd_valid;
  logic [PW-1:0] m_rd_data;
  bit            m_done;
  bit            m_pf;
  bit            m_ovf;
  bit            m_seen_low;

  logic [PW-1:0] ram [0:DEPTH-1];

  cap_buffer_ctrl #(
    .ADDR_WIDTH  (AW),
    .PACKET_WIDTH(PW),
    .FULL_MARGIN (FM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .cap_idle (cap_idle),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .page_full(page_full),
    .rd_req   (rd_req),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered single-port sample RAM.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_st        = M_IDLE;
    m_q.delete();
    m_wr_total  = 0;
    m_rd_total  = 0;
    m_infl      = 0;
    m_infl_data = '0;
    m_rd_valid  = 0;
    m_rd_data   = '0;
    m_done      = 0;
    m_pf        = 0;
    m_ovf       = 0;
    m_seen_low  = 0;
  endtask

  // One clock cycle: drive inputs, check at negedge, advance the model at posedge.
  task automatic applyStimulus(input bit st, input bit ab, input bit ci, input bit we,
                               input logic [PW-1:0] wd, input bit rr);
    bit ew, er, infl_prev;
    int sz;
    start    = st;
    abort    = ab;
    cap_idle = ci;
    wr_en    = we;
    wr_data  = wd;
    rd_req   = rr;
    sz = m_q.size();
    ew = !ab && m_st == M_CAPTURE && we && sz < DEPTH;
    er = !ab && m_st != M_IDLE && rr && sz > 0 && !we && !m_infl;
    @(negedge clk);
    checkOutput("mem_en", mem_en, ew || er);
    checkOutput("mem_we", mem_we, ew);
    if (ew) begin
      checkOutput("wr_addr", mem_addr, m_wr_total % DEPTH);
      checkOutput("mem_wdata", mem_wdata, wd);
    end else if (er) begin
      checkOutput("rd_addr", mem_addr, m_rd_total % DEPTH);
    end
    checkOutput("count", count, sz);
    checkOutput("page_full", page_full, m_pf);
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("busy", busy, m_st != M_IDLE);
    checkOutput("done", done, m_done);
    checkOutput("rd_valid", rd_valid, m_rd_valid);
    if (m_rd_valid) checkOutput("rd_data", rd_data, m_rd_data);
    @(posedge clk);
    infl_prev = m_infl;
    if (ab) begin
      m_st       = M_IDLE;
      m_q.delete();
      m_wr_total = 0;
      m_rd_total = 0;
      m_infl     = 0;
      m_rd_valid = 0;
      m_done     = 0;
      m_pf       = 0;
    end else begin
      m_rd_valid = m_infl;
      if (m_infl) m_rd_data = m_infl_data;
      m_infl = 0;
      m_done = 0;
      if (ew) begin
        m_q.push_back(wd);
        m_wr_total++;
      end
      if (m_st == M_CAPTURE && we && sz == DEPTH) m_ovf = 1;
      if (er) begin
        m_infl_data = m_q.pop_front();
        m_infl      = 1;
        m_rd_total++;
      end
      case (m_st)
        M_IDLE: if (st) begin
          m_st       = M_CAPTURE;
          m_q.delete();
          m_wr_total = 0;
          m_rd_total = 0;
          m_ovf      = 0;
          m_seen_low = 0;
        end
        M_CAPTURE: begin
          if (ci && m_seen_low) m_st = M_READOUT;
          else if (!ci)         m_seen_low = 1;
        end
        default: if (sz == 0 && !infl_prev) begin
          m_st   = M_IDLE;
          m_done = 1;
        end
      endcase
      m_pf = (m_q.size() >= DEPTH - FM) && m_st == M_CAPTURE;
    end
    #1;
  endtask

  task automatic doReset();
    start    = 0;
    abort    = 0;
    cap_idle = 1;
    wr_en    = 0;
    wr_data  = '0;
    rd_req   = 0;
    reset    = 1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_page_full", page_full, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    modelReset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && m_st != M_IDLE; i++) applyStimulus(0, 0, 1, 0, '0, 1);
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, 0, '0, 0);
    checkOutput("drain_busy", busy, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1;
    start       = 0;
    abort       = 0;
    cap_idle    = 1;
    wr_en       = 0;
    wr_data     = '0;
    rd_req      = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    doReset();
    applyStimulus(0, 0, 1, 0, '0, 0);

    // Reset in the middle of a capture holding five words.
    applyStimulus(1, 0, 1, 0, '0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 32'h100 + i, 0);
    doReset();
    applyStimulus(1, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, 32'h55, 0);
    applyStimulus(0, 0, 0, 0, '0, 0);
    drain();

    // Four packets, cap_idle still high from before start, then drain.
    applyStimulus(1, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, 0, '0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 32'hA0 + i, 0);
    drain();

    // Seventeen writes into a sixteen-word buffer.
    applyStimulus(1, 0, 1, 0, '0, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 1, 32'hB00 + i, 0);
    applyStimulus(0, 0, 0, 0, '0, 0);
    drain();

    // Read request held across back-to-back writes.
    applyStimulus(1, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, 32'hC0, 0);
    applyStimulus(0, 0, 0, 1, 32'hC1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 32'hC2 + i, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, '0, 1);
    drain();

    // Pointer wrap: write 12, read 12, write 8.
    applyStimulus(1, 0, 1, 0, '0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 32'hD00 + i, 0);
    for (int i = 0; i < 24; i++) applyStimulus(0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 8; i++)  applyStimulus(0, 0, 0, 1, 32'hE00 + i, 0);
    drain();

    // Abort on the cycle after a read issue.
    applyStimulus(1, 0, 1, 0, '0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 32'hF0 + i, 0);
    applyStimulus(0, 0, 0, 0, '0, 1);
    applyStimulus(0, 1, 0, 0, '0, 1);
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, 0, '0, 0);

    // Randomized sessions with occasional aborts and ignored starts.
    for (int s = 0; s < 40; s++) begin
      int n;
      applyStimulus(1, 0, 1'($urandom_range(0, 1)), 0, '0, 0);
      n = $urandom_range(4, 40);
      for (int c = 0; c < n; c++) begin
        applyStimulus(($urandom % 20) == 0, ($urandom % 80) == 0, 0,
                      ($urandom % 3) != 0, $urandom, 1'($urandom_range(0, 1)));
      end
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
